load_store_unit: RTL and testbench
==================================

# load_store_unit

Load/store unit between the execute stage and the byte-addressed 1 KiB data memory. Accepts one RV32I load or store request at a time over a valid/ready handshake, checks alignment and range, and drives the memory's `memaccess`/`size`/`Memaddr`/`datain` port for exactly one cycle. For loads it captures `dataout`, applies zero-extension for LBU/LHU (the memory itself always sign-extends), and returns the result and a fault code over a second valid/ready handshake.

## Interface
Parameters:
- `ADDR_W`, 10: memory byte-address width; addresses ≥ 2^ADDR_W are out of range.

Ports:
- `clk`  in  1  clock; all state changes on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  unit can accept a request.
- `req_store`  in  1  1 = store, 0 = load.
- `req_funct3`  in  3  RV32I funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- `req_addr`  in  32  effective byte address.
- `req_wdata`  in  32  store data, LSB-aligned.
- `resp_valid`  out  1  response present.
- `resp_ready`  in  1  consumer takes the response.
- `resp_rdata`  out  32  load result; 0 for stores and faults.
- `resp_fault`  out  2  00 ok, 01 misaligned, 10 out of range, 11 illegal funct3.
- `mem_access`  out  3  to memory `memaccess`: bit0 enable, bit1 write, bit2 read.
- `mem_size`  out  2  to memory `size`: 00 byte, 01 half, 10 word.
- `mem_addr`  out  ADDR_W  to memory `Memaddr`.
- `mem_wdata`  out  32  to memory `datain`.
- `mem_rdata`  in  32  from memory `dataout`.

## Operation
- FSM states: IDLE, ACCESS, LATCH, RESP.
- IDLE: `req_ready`=1. On `req_valid && req_ready`, register store, funct3, addr[ADDR_W-1:0], and wdata; then classify the request.
  - Illegal funct3 gives fault 11. Illegal values: 011, 110, and 111; for stores, any value above 010.
  - Otherwise, `req_addr[31:ADDR_W]` ≠ 0 gives fault 10.
  - Otherwise, a misaligned address gives fault 01: H/HU with addr[0]≠0, or W with addr[1:0]≠0.
  - Priority: 11 > 10 > 01.
  - Fault: go to RESP with no memory access. No fault: go to ACCESS.
- ACCESS: one cycle.
  - `mem_access` is 011 for a store and 101 for a load.
  - `mem_size` = funct3[1:0].
  - `mem_addr` and `mem_wdata` come from the registered request.
  - Next state: RESP for a store, LATCH for a load.
- LATCH: `mem_access`=000. Capture `mem_rdata` into the result register:
  - B, H, W: as delivered.
  - BU: {24'b0, rdata[7:0]}.
  - HU: {16'b0, rdata[15:0]}.
  - Then go to RESP.
- RESP: `resp_valid`=1 and outputs are held stable. On `resp_ready`, go to IDLE.
- `mem_access`=000 in every state except ACCESS. `mem_size`, `mem_addr`, `mem_wdata` are don't-care outside ACCESS, but must be driven from registers.
- Only one request is in flight. `req_ready`=0 in ACCESS, LATCH, and RESP.

## Timing
- Reset (async, takes effect immediately):
  - state = IDLE, `req_ready`=1, `resp_valid`=0, `resp_rdata`=0, `resp_fault`=00.
  - `mem_access`=000, `mem_size`=00, `mem_addr`=0, `mem_wdata`=0.
- Reset asserted during ACCESS forces `mem_access`=000 before the next edge, so no memory write occurs.
- Latency from the accept edge E0 to the first cycle with `resp_valid`=1:
  - Fault: 1 cycle.
  - Store: 2 cycles. The memory write happens at edge E1.
  - Load: 3 cycles. `mem_rdata` is valid after E1 and is captured at E2.
- Response backpressure: RESP holds indefinitely while `resp_ready`=0.
- Back-to-back: `resp_ready`=1 in RESP gives IDLE on the next cycle. Throughput is at best one request per 3 cycles for stores and 4 cycles for loads.
- `req_valid` asserted in a non-IDLE state is ignored, not queued. The requester must hold the request until `req_ready`.
- Address 1023 with byte access is legal. Half/word accesses that would wrap past 1023 are already rejected by the alignment check.

## Test plan
- Store then load, word: SW 0xDEADBEEF @0x010 → resp at +2, fault 00; LW @0x010 → resp at +3, rdata 0xDEADBEEF, fault 00.
- Extension: SB 0x80 @0x020, then LB @0x020 → 0xFFFFFF80, and LBU @0x020 → 0x00000080. SH 0x8001 @0x022, then LHU → 0x00008001.
- Faults: LW @0x013 → fault 01, 1-cycle latency, `mem_access` never ≠ 000. SW @0x400 → fault 10. Load funct3=011 → fault 11. SH funct3=100 → fault 11. SH @0x401 → fault 10 (range beats misalignment).
- Backpressure: hold `resp_ready`=0 for 5 cycles after a load → `resp_valid`, `resp_rdata`, `resp_fault` stable; `req_ready`=0; a second request is not accepted until after the handshake.
- Reset mid-op: SW 0x12345678 @0x030; assert `rst_n`=0 during ACCESS before the edge → `mem_access`=000 immediately and outputs at reset values. After release, LW @0x030 returns the prior contents, not 0x12345678.
- Boundary: SB 0xAA @0x3FF, then LBU @0x3FF → 0x000000AA, fault 00.

Source files
------------

// File: rtl/load_store_unit_if.sv
// Bundles the request, response and data-memory signals of the load/store unit.
// The slave modport is the unit itself; the master modport is its environment.
interface load_store_unit_if #(
  parameter int ADDR_W = 10
) ();
  logic              req_valid;
  logic              req_ready;
  logic              req_store;
  logic [2:0]        req_funct3;
  logic [31:0]       req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic              resp_ready;
  logic [31:0]       resp_rdata;
  logic [1:0]        resp_fault;
  logic [2:0]        mem_access;
  logic [1:0]        mem_size;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  modport slave (
    input  req_valid, req_store, req_funct3, req_addr, req_wdata, resp_ready, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_fault, mem_access, mem_size, mem_addr, mem_wdata
  );

  modport master (
    output req_valid, req_store, req_funct3, req_addr, req_wdata, resp_ready, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_fault, mem_access, mem_size, mem_addr, mem_wdata
  );
endinterface

// File: rtl/load_store_unit.sv
// Single-outstanding RV32I load/store unit in front of a byte-addressed data memory
// that always sign-extends; zero-extension for LBU/LHU is applied here.
module load_store_unit #(
  parameter int ADDR_W = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  load_store_unit_if.slave bus
);
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] LATCH  = 2'd2;
  localparam logic [1:0] RESP   = 2'd3;

  logic [1:0]        state;
  logic              r_store;
  logic [2:0]        r_funct3;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [31:0]       r_rdata;
  logic [1:0]        r_fault;

  logic       accept;
  logic       illegal;
  logic       out_of_range;
  logic       misaligned;
  logic [1:0] fault_code;

  assign accept = bus.req_valid && (state == IDLE);

  // Fault priority: illegal funct3, then range, then alignment.
  always_comb begin
    illegal      = (bus.req_funct3 == 3'b011) || (bus.req_funct3 == 3'b110) ||
                   (bus.req_funct3 == 3'b111) || (bus.req_store && (bus.req_funct3 > 3'b010));
    out_of_range = (bus.req_addr[31:ADDR_W] != '0);
    misaligned   = ((bus.req_funct3[1:0] == 2'b01) && bus.req_addr[0]) ||
                   ((bus.req_funct3[1:0] == 2'b10) && (bus.req_addr[1:0] != 2'b00));
    fault_code   = 2'b00;
    if (illegal)           fault_code = 2'b11;
    else if (out_of_range) fault_code = 2'b10;
    else if (misaligned)   fault_code = 2'b01;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      r_store  <= 1'b0;
      r_funct3 <= '0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rdata  <= '0;
      r_fault  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            r_store  <= bus.req_store;
            r_funct3 <= bus.req_funct3;
            r_addr   <= bus.req_addr[ADDR_W-1:0];
            r_wdata  <= bus.req_wdata;
            r_rdata  <= '0;
            r_fault  <= fault_code;
            state    <= (fault_code != 2'b00) ? RESP : ACCESS;
          end
        end
        ACCESS: state <= r_store ? RESP : LATCH;
        LATCH: begin
          case (r_funct3)
            3'b100:  r_rdata <= {24'b0, bus.mem_rdata[7:0]};
            3'b101:  r_rdata <= {16'b0, bus.mem_rdata[15:0]};
            default: r_rdata <= bus.mem_rdata;
          endcase
          state <= RESP;
        end
        RESP: begin
          if (bus.resp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // mem_access decodes straight from the state register so an asynchronous
  // reset during ACCESS removes the enable before the next edge.
  always_comb begin
    bus.mem_access = 3'b000;
    if (state == ACCESS) bus.mem_access = r_store ? 3'b011 : 3'b101;
  end

  assign bus.mem_size   = r_funct3[1:0];
  assign bus.mem_addr   = r_addr;
  assign bus.mem_wdata  = r_wdata;
  assign bus.req_ready  = (state == IDLE);
  assign bus.resp_valid = (state == RESP);
  assign bus.resp_rdata = r_rdata;
  assign bus.resp_fault = r_fault;
endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: a byte-array reference model predicts each
// response, a monitor compares whenever a response handshake occurs.
module tb_load_store_unit;
  logic clk;
  logic rst_n;

  load_store_unit_if #(.ADDR_W(10)) bus ();

  load_store_unit #(.ADDR_W(10)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic [1:0]  fault;
  } exp_t;

  exp_t        sbq[$];
  int unsigned total = 0;
  int unsigned bad   = 0;
  int unsigned acc_cnt = 0;
  logic [7:0]  mem     [1024];
  logic [7:0]  ref_mem [1024];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Data memory: write at the edge, read result (sign-extended) valid after the edge.
  always @(posedge clk) begin
    if (bus.mem_access != 3'b000) acc_cnt <= acc_cnt + 1;
    if (bus.mem_access == 3'b011) begin
      mem[bus.mem_addr] <= bus.mem_wdata[7:0];
      if (bus.mem_size != 2'b00) mem[bus.mem_addr + 10'd1] <= bus.mem_wdata[15:8];
      if (bus.mem_size == 2'b10) begin
        mem[bus.mem_addr + 10'd2] <= bus.mem_wdata[23:16];
        mem[bus.mem_addr + 10'd3] <= bus.mem_wdata[31:24];
      end
    end else if (bus.mem_access == 3'b101) begin
      case (bus.mem_size)
        2'b00:   bus.mem_rdata <= {{24{mem[bus.mem_addr][7]}}, mem[bus.mem_addr]};
        2'b01:   bus.mem_rdata <= {{16{mem[bus.mem_addr + 10'd1][7]}},
                                   mem[bus.mem_addr + 10'd1], mem[bus.mem_addr]};
        default: bus.mem_rdata <= {mem[bus.mem_addr + 10'd3], mem[bus.mem_addr + 10'd2],
                                   mem[bus.mem_addr + 10'd1], mem[bus.mem_addr]};
      endcase
    end
  end

  // Reference: classify with plain arithmetic, then move bytes little-endian.
  function automatic void model(input bit st, input logic [2:0] f3, input logic [31:0] a,
                                input logic [31:0] wd, output logic [31:0] r, output logic [1:0] f);
    int unsigned nb;
    int unsigned sz;
    r  = '0;
    sz = 0;
    case (f3)
      3'd0, 3'd4: sz = 1;
      3'd1, 3'd5: sz = 2;
      3'd2:       sz = 4;
      default:    sz = 0;
    endcase
    if (sz == 0 || (st && f3 > 3'd2))  f = 2'b11;
    else if (a >= 32'd1024)            f = 2'b10;
    else if ((a % sz) != 0)            f = 2'b01;
    else begin
      f  = 2'b00;
      nb = sz;
      if (st) begin
        for (int unsigned i = 0; i < nb; i++) ref_mem[a + i] = wd[8*i +: 8];
      end else begin
        for (int unsigned i = 0; i < nb; i++) r[8*i +: 8] = ref_mem[a + i];
        if (f3 == 3'd0) r = $unsigned(32'($signed(r[7:0])));
        if (f3 == 3'd1) r = $unsigned(32'($signed(r[15:0])));
      end
    end
  endfunction

  // Monitor: a response handshake completes on the edge after this sample.
  always @(negedge clk) begin
    if (rst_n && bus.resp_valid && bus.resp_ready) begin
      if (sbq.size() == 0) begin
        chk("unexpected_resp", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("resp_rdata", bus.resp_rdata, e.rdata);
        chk("resp_fault", 32'(bus.resp_fault), 32'(e.fault));
      end
    end
  end

  task automatic do_req(input bit st, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input int unsigned dly, input bit stray);
    logic [31:0] er;
    logic [1:0]  ef;
    logic [31:0] hold_r;
    logic [1:0]  hold_f;
    int unsigned n;
    int unsigned lat;
    int unsigned ac0;
    @(negedge clk);
    bus.req_store  = st;
    bus.req_funct3 = f3;
    bus.req_addr   = a;
    bus.req_wdata  = wd;
    bus.req_valid  = 1'b1;
    n = 0;
    while (!bus.req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      chk("req_ready_timeout", 32'd0, 32'd1);
      bus.req_valid = 1'b0;
      return;
    end
    model(st, f3, a, wd, er, ef);
    sbq.push_back('{er, ef});
    ac0 = acc_cnt;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    lat = 1;
    while (!bus.resp_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("latency", 32'(lat), (ef != 2'b00) ? 32'd1 : (st ? 32'd2 : 32'd3));
    hold_r = bus.resp_rdata;
    hold_f = bus.resp_fault;
    if (stray) begin
      bus.req_store  = 1'b1;
      bus.req_funct3 = 3'd2;
      bus.req_addr   = 32'h100;
      bus.req_wdata  = 32'hFFFF_FFFF;
      bus.req_valid  = 1'b1;
    end
    for (int unsigned i = 0; i < dly; i++) begin
      @(posedge clk);
      #1;
      chk("bp_valid", 32'(bus.resp_valid), 32'd1);
      chk("bp_rdata", bus.resp_rdata, hold_r);
      chk("bp_fault", 32'(bus.resp_fault), 32'(hold_f));
      chk("bp_req_ready", 32'(bus.req_ready), 32'd0);
    end
    bus.req_valid  = 1'b0;
    bus.resp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.resp_ready = 1'b0;
    chk("resp_dropped", 32'(bus.resp_valid), 32'd0);
    chk("ready_again", 32'(bus.req_ready), 32'd1);
    chk("mem_accesses", acc_cnt - ac0, (ef != 2'b00) ? 32'd0 : 32'd1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req_ready"},  32'(bus.req_ready),  32'd1);
    chk({tag, "_resp_valid"}, 32'(bus.resp_valid), 32'd0);
    chk({tag, "_resp_rdata"}, bus.resp_rdata,      32'd0);
    chk({tag, "_resp_fault"}, 32'(bus.resp_fault), 32'd0);
    chk({tag, "_mem_access"}, 32'(bus.mem_access), 32'd0);
    chk({tag, "_mem_size"},   32'(bus.mem_size),   32'd0);
    chk({tag, "_mem_addr"},   32'(bus.mem_addr),   32'd0);
    chk({tag, "_mem_wdata"},  bus.mem_wdata,       32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] a;
    logic [2:0]  f3;
    bit          st;
    for (int i = 0; i < 1024; i++) begin
      mem[i]     = 8'($urandom);
      ref_mem[i] = mem[i];
    end
    bus.req_valid  = 1'b0;
    bus.req_store  = 1'b0;
    bus.req_funct3 = '0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    bus.resp_ready = 1'b0;
    rst_n = 1'b0;
    #2;
    chk_reset_outputs("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Word store/load, extension, boundary byte
    do_req(1'b1, 3'd2, 32'h010, 32'hDEADBEEF, 0, 1'b0);
    do_req(1'b0, 3'd2, 32'h010, 32'h0, 0, 1'b0);
    do_req(1'b1, 3'd0, 32'h020, 32'h0000_0080, 0, 1'b0);
    do_req(1'b0, 3'd0, 32'h020, 32'h0, 0, 1'b0);
    do_req(1'b0, 3'd4, 32'h020, 32'h0, 0, 1'b0);
    do_req(1'b1, 3'd1, 32'h022, 32'h0000_8001, 0, 1'b0);
    do_req(1'b0, 3'd5, 32'h022, 32'h0, 0, 1'b0);
    do_req(1'b0, 3'd1, 32'h022, 32'h0, 1, 1'b0);
    do_req(1'b1, 3'd0, 32'h3FF, 32'h0000_00AA, 0, 1'b0);
    do_req(1'b0, 3'd4, 32'h3FF, 32'h0, 0, 1'b0);

    // Faults
    do_req(1'b0, 3'd2, 32'h013, 32'h0, 0, 1'b0);
    do_req(1'b1, 3'd2, 32'h400, 32'h1234_5678, 0, 1'b0);
    do_req(1'b0, 3'd3, 32'h010, 32'h0, 0, 1'b0);
    do_req(1'b1, 3'd4, 32'h020, 32'h55, 0, 1'b0);
    do_req(1'b1, 3'd1, 32'h401, 32'h55, 0, 1'b0);

    // Backpressure with a stray request held during RESP
    do_req(1'b0, 3'd2, 32'h010, 32'h0, 5, 1'b1);

    // Reset during ACCESS of a store
    do_req(1'b1, 3'd2, 32'h030, 32'h0BAD_F00D, 0, 1'b0);
    @(negedge clk);
    bus.req_store  = 1'b1;
    bus.req_funct3 = 3'd2;
    bus.req_addr   = 32'h030;
    bus.req_wdata  = 32'h1234_5678;
    bus.req_valid  = 1'b1;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    chk("access_before_reset", 32'(bus.mem_access), 32'd3);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midop");
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    do_req(1'b0, 3'd2, 32'h030, 32'h0, 0, 1'b0);

    // Random traffic
    for (int i = 0; i < 70; i++) begin
      st = 1'($urandom);
      f3 = ($urandom_range(0, 5) == 0) ? 3'($urandom) : 3'(($urandom_range(0, 4) == 3) ? 4 + $urandom_range(0, 1) : $urandom_range(0, 2));
      if ($urandom_range(0, 7) == 0) a = $urandom;
      else a = 32'($urandom_range(0, 1023));
      if ($urandom_range(0, 3) != 0) a = a & ~32'h3;
      do_req(st, f3, a, $urandom, $urandom_range(0, 3), 1'b0);
    end

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drained", 32'(sbq.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
